uart_rx_ctrl: RTL

Frame-sequencing controller for the UART receiver datapath. Detects the start edge on RX_IN and runs the edge/bit counters. Drives the enables for the data sampler, deserializer and start/parity/stop checkers, and issues data_valid or an error pulse per frame. Sits inside the UART_RX top, between the serial input and the sampler/deserializer/checker blocks.

---
 rtl/uart_rx_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// Frame-sequencing controller for the UART receiver: start detection, edge/bit
// counting, checker/deserializer strobes and per-frame result pulses.
module uart_rx_ctrl #(
  parameter int unsigned PRESC_W      = 6,
  parameter int unsigned FRAME_BITS_W = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    RX_IN,
  input  logic [PRESC_W-1:0]      prescale,
  input  logic                    PAR_EN,
  input  logic                    strt_glitch,
  input  logic                    par_err,
  input  logic                    stp_err,
  output logic [PRESC_W-1:0]      edge_cnt,
  output logic [FRAME_BITS_W-1:0] bit_cnt,
  output logic                    dat_samp_en,
  output logic                    deser_en,
  output logic                    strt_chk_en,
  output logic                    par_chk_en,
  output logic                    stp_chk_en,
  output logic                    data_valid,
  output logic                    parity_err,
  output logic                    framing_err,
  output logic                    busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_e;

  localparam logic [PRESC_W-1:0]      P_MIN     = PRESC_W'(8);
  localparam logic [FRAME_BITS_W-1:0] LAST_DATA = FRAME_BITS_W'(8);

  state_e                  state_q, state_n;
  logic [PRESC_W-1:0]      p_q, p_n;
  logic                    par_q, par_n;
  logic                    perr_q, perr_n;
  logic                    serr_q, serr_n;
  logic [PRESC_W-1:0]      edge_n;
  logic [FRAME_BITS_W-1:0] bit_n;
  logic [PRESC_W-1:0]      ce_q, ce_n;
  logic                    wrap;
  logic                    deser_n, strt_n, parc_n, stpc_n, dv_n, pe_n, fe_n, busy_n;

  // Check edge sits two clocks past mid-bit, where the sampler's majority is stable.
  assign ce_q = (p_q >> 1) + PRESC_W'(2);
  assign wrap = (edge_cnt == p_q - PRESC_W'(1));

  // Next-state, counters, latched config and registered-output next values.
  always_comb begin
    state_n = state_q;
    p_n     = p_q;
    par_n   = par_q;
    perr_n  = perr_q;
    serr_n  = serr_q;
    edge_n  = wrap ? '0 : edge_cnt + PRESC_W'(1);
    bit_n   = wrap ? bit_cnt + FRAME_BITS_W'(1) : bit_cnt;
    ce_n    = '0;
    deser_n = 1'b0;
    strt_n  = 1'b0;
    parc_n  = 1'b0;
    stpc_n  = 1'b0;
    dv_n    = 1'b0;
    pe_n    = 1'b0;
    fe_n    = 1'b0;
    busy_n  = 1'b0;
    case (state_q)
      IDLE: begin
        edge_n = '0;
        bit_n  = '0;
        perr_n = 1'b0;
        serr_n = 1'b0;
        if (!RX_IN) begin
          state_n = START;
          p_n     = (prescale < P_MIN) ? P_MIN : prescale;
          par_n   = PAR_EN;
        end
      end
      START: begin
        if (edge_cnt == ce_q && strt_glitch) begin
          state_n = IDLE;
          edge_n  = '0;
          bit_n   = '0;
        end else if (wrap) begin
          state_n = DATA;
        end
      end
      DATA: begin
        if (wrap && bit_cnt == LAST_DATA) state_n = par_q ? PARITY : STOP;
      end
      PARITY: begin
        if (edge_cnt == ce_q && par_err) perr_n = 1'b1;
        if (wrap) state_n = STOP;
      end
      STOP: begin
        // Leave right after the check so a back-to-back start edge is not missed.
        if (edge_cnt == ce_q) begin
          serr_n  = stp_err;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
        edge_n  = '0;
        bit_n   = '0;
      end
      default: begin
        state_n = IDLE;
        edge_n  = '0;
        bit_n   = '0;
      end
    endcase
    ce_n    = (p_n >> 1) + PRESC_W'(2);
    busy_n  = (state_n != IDLE);
    strt_n  = (state_n == START)  && (edge_n == ce_n);
    deser_n = (state_n == DATA)   && (edge_n == ce_n);
    parc_n  = (state_n == PARITY) && (edge_n == ce_n);
    stpc_n  = (state_n == STOP)   && (edge_n == ce_n);
    dv_n    = (state_n == DONE) && !perr_n && !serr_n;
    pe_n    = (state_n == DONE) && perr_n;
    fe_n    = (state_n == DONE) && serr_n;
  end

  // State, config and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      p_q         <= P_MIN;
      par_q       <= 1'b0;
      perr_q      <= 1'b0;
      serr_q      <= 1'b0;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      dat_samp_en <= 1'b0;
      deser_en    <= 1'b0;
      strt_chk_en <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_n;
      p_q         <= p_n;
      par_q       <= par_n;
      perr_q      <= perr_n;
      serr_q      <= serr_n;
      edge_cnt    <= edge_n;
      bit_cnt     <= bit_n;
      dat_samp_en <= busy_n;
      deser_en    <= deser_n;
      strt_chk_en <= strt_n;
      par_chk_en  <= parc_n;
      stp_chk_en  <= stpc_n;
      data_valid  <= dv_n;
      parity_err  <= pe_n;
      framing_err <= fe_n;
      busy        <= busy_n;
    end
  end

endmodule
